// File: rtl/rj_phase_monitor.sv
// Sequence checker for a ring/Johnson counter: decodes phase, tracks lock,
// flags faults while locked and counts completed revolutions.
module rj_phase_monitor #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned LOCK_CNT = 2,
  parameter int unsigned REV_W    = 8,
  parameter int unsigned ERR_W    = 8,
  localparam int unsigned PW      = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] q,
  input  logic             rj,
  input  logic             clr,
  output logic [PW-1:0]    phase,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic             rev_pulse,
  output logic [REV_W-1:0] rev_cnt
);

  localparam int unsigned MW = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {StSearch, StTrack, StLocked} state_e;

  function automatic logic [WIDTH-1:0] next_code(input logic [WIDTH-1:0] x, input logic m);
    return m ? {x[WIDTH-2:0], ~x[WIDTH-1]} : {x[WIDTH-2:0], x[WIDTH-1]};
  endfunction

  function automatic logic is_legal(input logic [WIDTH-1:0] x, input logic m);
    logic             ok;
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] mask;
    ok   = 1'b0;
    ones = '1;
    if (m) begin
      // Johnson codes are a low-aligned run of ones or its complement.
      for (int unsigned k = 0; k <= WIDTH; k++) begin
        mask = ~(ones << k);
        if (x == mask || x == ~mask) ok = 1'b1;
      end
    end else begin
      ok = ($countones(x) == 1);
    end
    return ok;
  endfunction

  function automatic logic [PW-1:0] decode(input logic [WIDTH-1:0] x, input logic m);
    int unsigned p;
    int unsigned pc;
    p  = 0;
    pc = $countones(x);
    if (m) begin
      p = x[0] ? pc : (2 * WIDTH - pc) % (2 * WIDTH);
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (x[i]) p = i;
      end
    end
    return PW'(p);
  endfunction

  // Stage 1 sample registers
  logic [WIDTH-1:0] q_s, q_p;
  logic             rj_s, rj_p;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_s  <= '0;
      q_p  <= '0;
      rj_s <= 1'b0;
      rj_p <= 1'b0;
    end else begin
      q_s  <= q;
      q_p  <= q_s;
      rj_s <= rj;
      rj_p <= rj_s;
    end
  end

  // Stage 2 evaluation
  state_e           state_q, state_d;
  logic [MW-1:0]    mcnt_q, mcnt_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic             err_q, err_d;
  logic             rev_q, rev_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [REV_W-1:0] rev_cnt_q, rev_cnt_d;

  logic             legal, match, mode_chg;
  logic [WIDTH-1:0] last_code, reset_code;

  assign legal      = is_legal(q_s, rj_s);
  assign match      = (q_s == next_code(q_p, rj_s));
  assign mode_chg   = (rj_s != rj_p);
  assign last_code  = {1'b1, {(WIDTH-1){1'b0}}};
  assign reset_code = rj_s ? '0 : {{(WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    state_d   = state_q;
    mcnt_d    = mcnt_q;
    err_d     = 1'b0;
    rev_d     = 1'b0;
    phase_d   = legal ? decode(q_s, rj_s) : phase_q;

    if (mode_chg) begin
      // A mode switch is a deliberate restart, not a fault.
      state_d = StSearch;
      mcnt_d  = '0;
    end else begin
      case (state_q)
        StSearch: begin
          if (legal) begin
            state_d = StTrack;
            mcnt_d  = '0;
          end
        end
        StTrack: begin
          if (!legal) begin
            state_d = StSearch;
            mcnt_d  = '0;
          end else if (match) begin
            mcnt_d = mcnt_q + 1'b1;
            if (mcnt_d == MW'(LOCK_CNT)) state_d = StLocked;
          end else begin
            mcnt_d = '0;
          end
        end
        StLocked: begin
          if (legal && match) begin
            rev_d = (q_p == last_code) && (q_s == reset_code);
          end else begin
            err_d   = 1'b1;
            mcnt_d  = '0;
            state_d = legal ? StTrack : StSearch;
          end
        end
        default: begin
          state_d = StSearch;
          mcnt_d  = '0;
        end
      endcase
    end

    if (clr) begin
      err_cnt_d = '0;
      rev_cnt_d = '0;
    end else begin
      err_cnt_d = (err_d && err_cnt_q != '1) ? err_cnt_q + 1'b1 : err_cnt_q;
      rev_cnt_d = rev_d ? rev_cnt_q + 1'b1 : rev_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StSearch;
      mcnt_q    <= '0;
      phase_q   <= '0;
      err_q     <= 1'b0;
      rev_q     <= 1'b0;
      err_cnt_q <= '0;
      rev_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mcnt_q    <= mcnt_d;
      phase_q   <= phase_d;
      err_q     <= err_d;
      rev_q     <= rev_d;
      err_cnt_q <= err_cnt_d;
      rev_cnt_q <= rev_cnt_d;
    end
  end

  assign phase     = phase_q;
  assign locked    = (state_q == StLocked);
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;
  assign rev_pulse = rev_q;
  assign rev_cnt   = rev_cnt_q;

endmodule

// File: tb/tb_rj_phase_monitor.sv
// Bench for rj_phase_monitor: table-driven sequence model checked every cycle,
// plus hand-derived checkpoints for the directed scenarios.
module tb_rj_phase_monitor;

  localparam int LOCK = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] q;
  logic       rj;
  logic       clr;
  logic [2:0] phase;
  logic       locked;
  logic       err;
  logic [7:0] err_cnt;
  logic       rev_pulse;
  logic [7:0] rev_cnt;

  int errors = 0;
  int checks = 0;

  rj_phase_monitor #(
    .WIDTH    (4),
    .LOCK_CNT (LOCK),
    .REV_W    (8),
    .ERR_W    (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .q         (q),
    .rj        (rj),
    .clr       (clr),
    .phase     (phase),
    .locked    (locked),
    .err       (err),
    .err_cnt   (err_cnt),
    .rev_pulse (rev_pulse),
    .rev_cnt   (rev_cnt)
  );

  always #5 clk = ~clk;

  // k-th code of the cycle: ring = single bit k; Johnson = k low ones, then ones shifting out
  function automatic logic [3:0] code_at(input bit m, input int k);
    logic [3:0] all;
    all = 4'hF;
    if (!m) return 4'(1 << k);
    if (k <= 4) return 4'((1 << k) - 1);
    return all << (k - 4);
  endfunction

  function automatic int idx_of(input logic [3:0] c, input bit m);
    int n;
    n = m ? 8 : 4;
    for (int k = 0; k < n; k++) begin
      if (code_at(m, k) == c) return k;
    end
    return -1;
  endfunction

  typedef struct {
    logic [3:0] qs, qp;
    logic       rjs, rjp;
    bit         tracking;
    int         streak;
    int         phase;
    bit         locked, err, rev;
    int         errcnt, revcnt;
  } mstate_t;

  mstate_t st;

  function automatic mstate_t model_next(input mstate_t s, input logic [3:0] qi,
                                         input logic rji, input logic clri);
    mstate_t n;
    int      ncodes, is, ip;
    bit      legal, match;
    n      = s;
    ncodes = s.rjs ? 8 : 4;
    is     = idx_of(s.qs, s.rjs);
    ip     = idx_of(s.qp, s.rjs);
    legal  = (is >= 0);
    match  = legal && (ip >= 0) && (is == (ip + 1) % ncodes);
    n.err  = 0;
    n.rev  = 0;
    if (legal) n.phase = is;
    if (s.rjs != s.rjp) begin
      n.tracking = 0;
      n.streak   = 0;
    end else if (!s.tracking) begin
      if (legal) begin
        n.tracking = 1;
        n.streak   = 0;
      end
    end else if (s.streak < LOCK) begin
      if (!legal) n.tracking = 0;
      else if (match) n.streak = s.streak + 1;
      else n.streak = 0;
    end else if (match) begin
      n.streak = LOCK;
      n.rev    = (ip == ncodes - 1) && (is == 0);
    end else begin
      n.err      = 1;
      n.streak   = 0;
      n.tracking = legal;
    end
    n.locked = n.tracking && (n.streak >= LOCK);
    if (clri) begin
      n.errcnt = 0;
      n.revcnt = 0;
    end else begin
      if (n.err && s.errcnt < 255) n.errcnt = s.errcnt + 1;
      if (n.rev) n.revcnt = (s.revcnt + 1) % 256;
    end
    n.qp  = s.qs;
    n.qs  = qi;
    n.rjp = s.rjs;
    n.rjs = rji;
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) st <= '{default: 0};
    else      st <= model_next(st, q, rj, clr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      check("phase",     32'(phase),     st.phase);
      check("locked",    32'(locked),    32'(st.locked));
      check("err",       32'(err),       32'(st.err));
      check("err_cnt",   32'(err_cnt),   st.errcnt);
      check("rev_pulse", 32'(rev_pulse), 32'(st.rev));
      check("rev_cnt",   32'(rev_cnt),   st.revcnt);
    end
  end

  task automatic tick(input logic [3:0] qv, input logic rjv, input logic clrv);
    @(negedge clk);
    q   = qv;
    rj  = rjv;
    clr = clrv;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_phase"},   32'(phase),     0);
    check({tag, "_locked"},  32'(locked),    0);
    check({tag, "_err"},     32'(err),       0);
    check({tag, "_err_cnt"}, 32'(err_cnt),   0);
    check({tag, "_rev"},     32'(rev_pulse), 0);
    check({tag, "_rev_cnt"}, 32'(rev_cnt),   0);
  endtask

  int         jx;
  int         ix;
  int         r;
  bit         m;
  logic [3:0] qv;

  initial begin
    rst = 1'b0;
    q   = 4'h0;
    rj  = 1'b0;
    clr = 1'b0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Ring run
    for (int i = 0; i < 12; i++) begin
      tick(code_at(0, i % 4), 1'b0, 1'b0);
      if (i >= 1 && i <= 4) check("t1_phase", 32'(phase), (i - 1) % 4);
      if (i == 2) check("t1_unlocked", 32'(locked), 0);
      if (i == 3) check("t1_locked", 32'(locked), 1);
      if (i == 5) begin
        check("t1_rev_pulse", 32'(rev_pulse), 1);
        check("t1_rev_cnt", 32'(rev_cnt), 1);
      end
    end
    check("t1_rev_cnt_end", 32'(rev_cnt), 2);

    // Johnson run from 0000
    for (int j = 0; j < 16; j++) begin
      tick(code_at(1, j % 8), 1'b1, 1'b0);
      if (j == 6) check("t2_phase_1110", 32'(phase), 5);
      if (j == 8) check("t2_rev_cnt_pre", 32'(rev_cnt), 2);
      if (j == 9) begin
        check("t2_rev_pulse", 32'(rev_pulse), 1);
        check("t2_rev_cnt", 32'(rev_cnt), 3);
      end
    end
    check("t2_err_cnt", 32'(err_cnt), 0);

    // Locked ring, one illegal sample
    for (int i = 0; i < 8; i++) tick(code_at(0, i % 4), 1'b0, 1'b0);
    tick(4'b0011, 1'b0, 1'b0);
    tick(code_at(0, 0), 1'b0, 1'b0);
    check("t3_err", 32'(err), 1);
    check("t3_locked", 32'(locked), 0);
    check("t3_err_cnt", 32'(err_cnt), 1);
    check("t3_phase_hold", 32'(phase), 3);
    for (int i = 1; i < 4; i++) begin
      tick(code_at(0, i), 1'b0, 1'b0);
      if (i == 1) check("t3_err_clear", 32'(err), 0);
      if (i == 3) check("t3_relock", 32'(locked), 1);
    end

    // Switch to Johnson while locked
    jx = 0;
    for (int g = 0; g < 8; g++) begin
      tick(code_at(1, jx % 8), 1'b1, 1'b0);
      jx++;
      if (g == 1) begin
        check("t4_locked", 32'(locked), 0);
        check("t4_err", 32'(err), 0);
        check("t4_err_cnt", 32'(err_cnt), 1);
      end
      if (g == 4) check("t4_relock", 32'(locked), 1);
    end

    // Saturate the fault counter
    for (int k = 0; k < 259; k++) begin
      for (int s = 0; s < 3; s++) begin
        tick(code_at(1, jx % 8), 1'b1, 1'b0);
        jx++;
      end
      tick(4'b0101, 1'b1, 1'b0);
    end
    check("t5_sat", 32'(err_cnt), 255);
    tick(code_at(1, jx % 8), 1'b1, 1'b1);
    jx++;
    check("t5_clr_err_pulse", 32'(err), 1);
    check("t5_clr_err_cnt", 32'(err_cnt), 0);
    check("t5_clr_rev_cnt", 32'(rev_cnt), 0);

    // Reset asserted during an err pulse
    for (int s = 0; s < 3; s++) begin
      tick(code_at(1, jx % 8), 1'b1, 1'b0);
      jx++;
    end
    tick(4'b0101, 1'b1, 1'b0);
    tick(code_at(1, jx % 8), 1'b1, 1'b0);
    check("t6_err_before_rst", 32'(err), 1);
    #2;
    rst = 1'b0;
    q   = 4'h0;
    rj  = 1'b0;
    #1;
    check_all_zero("t6_async");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(code_at(0, i % 4), 1'b0, 1'b0);
      if (i == 2) check("t6_unlocked", 32'(locked), 0);
      if (i == 3) check("t6_relock", 32'(locked), 1);
      if (i == 5) check("t6_rev_restart", 32'(rev_cnt), 1);
    end

    // Random mix: mostly legal progress, some corrupt codes, mode restarts, clears
    m  = 1'b0;
    ix = 3;
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        m  = ~m;
        ix = 0;
        qv = code_at(m, 0);
      end else if (r < 12) begin
        qv = 4'($urandom_range(0, 15));
      end else begin
        ix = (ix + 1) % (m ? 8 : 4);
        qv = code_at(m, ix);
      end
      tick(qv, m, ($urandom_range(0, 39) == 0));
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
